// File: rtl/pong_engine.sv
// pong_engine: tick-stepped Pong physics, paddles, scoring and serve/point/game-over sequencing
module pong_engine #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_X_OFF = 16,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int AI_SPEED     = 3,
    parameter int SERVE_DELAY  = 60,
    parameter int SCORE_MAX    = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       ai_en,
    input  logic       serve,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] p1_y,
    output logic [9:0] p2_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] state,
    output logic       point_pulse,
    output logic       game_over
);
    localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_POINT = 2'd2, S_OVER = 2'd3;
    localparam logic [10:0] CX = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [10:0] CY = 11'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] PC = 11'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [10:0] YMAX = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] XMAX = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] PMAX = 11'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] L_FACE = 11'(PADDLE_X_OFF + PADDLE_W);
    localparam logic [10:0] R_LIM = 11'(SCREEN_W - PADDLE_X_OFF - PADDLE_W - BALL_SIZE);
    localparam logic [10:0] BS = 11'(BALL_SPEED);
    localparam logic [10:0] BSZ = 11'(BALL_SIZE);
    localparam logic [10:0] PH = 11'(PADDLE_H);
    localparam logic [10:0] HB = 11'(BALL_SIZE / 2);
    localparam logic [10:0] HP = 11'(PADDLE_H / 2);
    localparam logic [10:0] PSPD = 11'(PADDLE_SPEED);
    localparam logic [10:0] ASPD = 11'(AI_SPEED);
    localparam int CW = $clog2(SERVE_DELAY + 1);
    localparam logic [CW-1:0] CNT_END = CW'(SERVE_DELAY - 1);
    localparam logic [3:0] SMAX = 4'(SCORE_MAX);

    logic [1:0] state_nx;
    logic dir_x, dir_y, serve_dir;
    logic [CW-1:0] cnt;
    logic [10:0] bx, by, p1, p2, bc, pc2;
    logic [9:0] x_nx, y_nx, p1_nx, p2_nx;
    logic [3:0] s1_nx, s2_nx;
    logic dy_nx, ov1, ov2, hit_l, hit_r, miss_l, miss_r, miss, play_tick;

    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};
    assign p1 = {1'b0, p1_y};
    assign p2 = {1'b0, p2_y};

    function automatic logic [9:0] pad(input logic [9:0] y, input logic up, input logic dn,
                                       input logic [10:0] spd);
        logic [10:0] y1;
        y1 = {1'b0, y};
        if (up && !dn)
            return y1 <= spd ? 10'd0 : 10'(y1 - spd);
        if (dn && !up)
            return y1 + spd >= PMAX ? 10'(PMAX) : 10'(y1 + spd);
        return y;
    endfunction

    always_comb begin
        play_tick = tick && state == S_PLAY;
        ov1 = by + BSZ > p1 && by < p1 + PH;
        ov2 = by + BSZ > p2 && by < p2 + PH;
        hit_l = !dir_x && bx >= L_FACE && bx <= L_FACE + BS && ov1;
        hit_r = dir_x && bx <= R_LIM && bx + BS >= R_LIM && ov2;
        miss_l = !dir_x && bx <= BS && !hit_l;
        miss_r = dir_x && bx + BS >= XMAX && !hit_r;
        miss = miss_l || miss_r;
        y_nx = dir_y ? (by + BS >= YMAX ? 10'(YMAX) : 10'(by + BS)) : (by <= BS ? 10'd0 : 10'(by - BS));
        dy_nx = dir_y ? !(by + BS >= YMAX) : by <= BS;
        x_nx = hit_l ? 10'(L_FACE) : hit_r ? 10'(R_LIM) : dir_x ? 10'(bx + BS) : 10'(bx - BS);
        s1_nx = score_p1 + {3'b0, miss_r};
        s2_nx = score_p2 + {3'b0, miss_l};
        bc = by + HB;
        pc2 = p2 + HP;
        p1_nx = pad(p1_y, p1_up, p1_down, PSPD);
        p2_nx = ai_en ? pad(p2_y, bc < pc2, bc > pc2, ASPD) : pad(p2_y, p2_up, p2_down, PSPD);
    end

    always_ff @(posedge clk)
        state <= !rst_n ? S_IDLE : state_nx;

    always_comb
        state_nx = (state == S_IDLE && serve) ? S_PLAY :
                   (state == S_OVER && serve) ? S_IDLE :
                   (play_tick && miss) ? ((s1_nx == SMAX || s2_nx == SMAX) ? S_OVER : S_POINT) :
                   (tick && state == S_POINT && cnt == CNT_END) ? S_PLAY : state;

    always_comb
        game_over = state == S_OVER;

    // dir_x/serve_dir: 1 = right; dir_y: 1 = down
    always_ff @(posedge clk) begin
        if (!rst_n || (state == S_OVER && serve)) begin
            ball_x <= 10'(CX);
            ball_y <= 10'(CY);
            p1_y <= 10'(PC);
            p2_y <= 10'(PC);
            score_p1 <= '0;
            score_p2 <= '0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
            serve_dir <= 1'b1;
            cnt <= '0;
            point_pulse <= 1'b0;
        end else begin
            point_pulse <= play_tick && miss;
            if (state == S_IDLE && serve) begin
                dir_x <= serve_dir;
                dir_y <= 1'b1;
            end else if (tick && state != S_OVER) begin
                p1_y <= p1_nx;
                p2_y <= p2_nx;
                if (state == S_POINT) begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_END)
                        dir_x <= serve_dir;
                end
                if (state == S_PLAY && miss) begin
                    ball_x <= 10'(CX);
                    ball_y <= 10'(CY);
                    score_p1 <= s1_nx;
                    score_p2 <= s2_nx;
                    serve_dir <= miss_r;
                    cnt <= '0;
                end else if (state == S_PLAY) begin
                    ball_x <= x_nx;
                    ball_y <= y_nx;
                    dir_x <= dir_x ^ (hit_l || hit_r);
                    dir_y <= dy_nx;
                end
            end
        end
    end
endmodule
